pio_mem_rd_arb: RTL and testbench
=================================

Name: pio_mem_rd_arb

Overview:
- Round-robin arbiter that shares the single application read port of a PIO-accessible memory between NREQ requesters.
- Issues at most one read per cycle and tags every issued read with its requester ID.
- Routes each returned ack and data back to the requester that issued it.
- Bounds app-side read bursts so a pending PIO read is guaranteed to complete, because the memory always gives the app port priority.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 20, memory data width.
- DEPTH_NBITS, 10, memory address width.
- MAX_BURST, 8, consecutive issue cycles allowed while a PIO read is pending (1..255).
- OUTST, 4, depth of the outstanding-ID FIFO (must be at least 4).

Ports:
- clk  in  1  single clock.
- `RESET_SIG  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester read request; held, with its address, until gnt.
- raddr  in  NREQ*DEPTH_NBITS  packed addresses; requester i uses slice [i*DEPTH_NBITS +: DEPTH_NBITS].
- gnt  out  NREQ  one-hot registered grant.
- rsp_valid  out  NREQ  one-hot registered read-data valid.
- rsp_data  out  WIDTH  read data, broadcast to all requesters, qualified by rsp_valid.
- pio_rd  in  1  PIO read strobe to this memory (reg_ms & reg_rd).
- mem_ack  in  1  PIO ack from the memory.
- app_mem_rd  out  1  read strobe to the memory app port.
- app_mem_raddr  out  DEPTH_NBITS  read address to the memory.
- app_mem_ack  in  1  app read ack from the memory.
- app_mem_rdata  in  WIDTH  app read data from the memory.

Behaviour:
- Reset: all outputs are 0. Round-robin pointer = 0. FIFO is empty. burst_cnt = 0. pio_pend = 0. State = RUN.
- Eligible set: elig = req & ~gnt. This prevents a second grant to a requester in the same cycle it sees gnt.
- Selection: the winner is the first set bit of elig scanning from ptr upward, modulo NREQ.
- Issue condition: state == RUN, elig is non-zero, and the FIFO is not full.
- On issue, the following are registered for the next cycle:
  - gnt[w] = 1;
  - app_mem_rd = 1;
  - app_mem_raddr = raddr slice w;
  - w is pushed into the ID FIFO;
  - ptr = (w + 1) mod NREQ.
- When not issuing: gnt = 0, app_mem_rd = 0, app_mem_raddr holds its value, ptr holds.
- ID FIFO:
  - Pop on app_mem_ack. The next registered cycle gives rsp_valid[popped ID] = 1 and rsp_data = app_mem_rdata.
  - Simultaneous push and pop leaves the count unchanged.
  - Push when full cannot occur, because issue is blocked when full.
  - app_mem_ack with the FIFO empty is an error: drop it and assert no rsp_valid.
- End-to-end latency: req sampled at cycle T → gnt/app_mem_rd at T+1 → app_mem_ack at T+4 → rsp_valid at T+5.
- pio_pend: set on pio_rd, cleared on mem_ack. If both occur in the same cycle, set wins.
- burst_cnt: increments (saturating at 255) on every issue cycle and clears on any non-issue cycle.
- FSM:
  - RUN → YIELD when pio_pend && burst_cnt >= MAX_BURST. The transition suppresses issue in the same cycle.
  - YIELD issues nothing (app_mem_rd low, so the memory serves the saved PIO read).
  - YIELD → RUN on mem_ack, which also clears burst_cnt.
  - Requests stay pending through YIELD; arbitration state (ptr) is preserved.
- Reset mid-operation clears everything immediately. Reads in flight are lost and no rsp_valid is generated for them.

Test Plan:
- Single read: req=4'b0010, raddr[1]=0x05A, memory holds 0x12345 → gnt=4'b0010 at T+1, app_mem_raddr=0x05A, rsp_valid=4'b0010 with rsp_data=0x12345 at T+5.
- Round robin: req=4'b1111 held and each requester drops req after its gnt → grants in order 0,1,2,3, one per cycle, with rsp_valid order 0,1,2,3.
- Re-grant guard: requester 0 alone keeps req high continuously → gnt[0] is high every other cycle, never on two consecutive cycles.
- PIO fairness: all requesters streaming with pio_rd pulsed at cycle 0 and MAX_BURST=8 → app_mem_rd drops after 8 issue cycles. It stays low until mem_ack, then resumes at the ptr following the last winner. The PIO read returns the correct data.
- Backpressure: force app_mem_ack low (memory stub) → issue stops when 4 reads are outstanding. After 4 acks, 4 rsp_valids arrive with the correct IDs and data.
- Async reset asserted with 3 reads outstanding → outputs 0 immediately. After release, the first request is served with the normal T+5 latency and no stale rsp_valid appears.

Source files
------------

// File: rtl/pio_mem_rd_arb_if.sv
// Bus bundle between the PIO-memory read arbiter and its neighbours.
//   requester side : req, raddr (packed per requester), gnt, rsp_valid, rsp_data
//   PIO side       : pio_rd (PIO read strobe seen by the memory), mem_ack
//   memory side    : app_mem_rd, app_mem_raddr, app_mem_ack, app_mem_rdata
// slave  = the arbiter's view, master = the surrounding logic's view.
interface pio_mem_rd_arb_if #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 10
);
  logic [NREQ-1:0]             req;
  logic [NREQ*DEPTH_NBITS-1:0] raddr;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rsp_valid;
  logic [WIDTH-1:0]            rsp_data;
  logic                        pio_rd;
  logic                        mem_ack;
  logic                        app_mem_rd;
  logic [DEPTH_NBITS-1:0]      app_mem_raddr;
  logic                        app_mem_ack;
  logic [WIDTH-1:0]            app_mem_rdata;

  modport slave (
    input  req, raddr, pio_rd, mem_ack, app_mem_ack, app_mem_rdata,
    output gnt, rsp_valid, rsp_data, app_mem_rd, app_mem_raddr
  );

  modport master (
    output req, raddr, pio_rd, mem_ack, app_mem_ack, app_mem_rdata,
    input  gnt, rsp_valid, rsp_data, app_mem_rd, app_mem_raddr
  );
endinterface

// File: rtl/pio_mem_rd_arb.sv
// Round-robin arbiter sharing the app read port of a PIO-accessible memory
// between NREQ requesters. One read issued per cycle, tagged with the
// requester ID in a small in-order FIFO so returned data is steered back.
// The memory always favours the app port, so app bursts are capped at
// MAX_BURST while a PIO read is pending; the arbiter then goes quiet until
// the PIO read is acked.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pio_mem_rd_arb_if.slave (requester, PIO and memory signals)

// Per-requester output lane: registered grant and response-valid bits.
module pio_mem_rd_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           issue,
  input  logic [IDW-1:0] win,
  input  logic           pop,
  input  logic [IDW-1:0] pop_id,
  output logic           gnt,
  output logic           rsp_valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      gnt       <= issue && (win == IDW'(LANE));
      rsp_valid <= pop && (pop_id == IDW'(LANE));
    end
  end
endmodule

module pio_mem_rd_arb #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 10,
  parameter int MAX_BURST   = 8,
  parameter int OUTST       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pio_mem_rd_arb_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW  = $clog2(OUTST + 1);

  typedef enum logic {RUN, YIELD} state_t;

  state_t                 state, state_nxt;
  logic                   yield_go;
  logic [IDW-1:0]         ptr;
  logic [NREQ-1:0]        elig;
  logic [IDW-1:0]         win;
  logic [IDW:0]           cand;
  logic                   found;
  logic                   issue;
  logic [DEPTH_NBITS-1:0] win_addr;
  logic [7:0]             burst_cnt;
  logic                   pio_pend;

  logic [IDW-1:0]         id_mem [OUTST];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          cnt;
  logic                   full, empty, pop;
  logic [IDW-1:0]         pop_id;

  logic [NREQ-1:0]        gnt_q, rsp_q;
  logic                   rd_q;
  logic [DEPTH_NBITS-1:0] raddr_q;
  logic [WIDTH-1:0]       rdata_q;

  // A requester sees gnt one cycle after issue and still holds req that
  // cycle; masking it avoids issuing its already-served request twice.
  assign elig = bus.req & ~gnt_q;

  // First eligible requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && elig[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  assign win_addr = bus.raddr[int'(win)*DEPTH_NBITS +: DEPTH_NBITS];

  // FSM: RUN arbitrates; YIELD keeps the app port idle so the memory can
  // serve the pending PIO read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    yield_go  = 1'b0;
    case (state)
      RUN: begin
        if (pio_pend && (burst_cnt >= 8'(MAX_BURST))) begin
          state_nxt = YIELD;
          yield_go  = 1'b1;
        end
      end
      YIELD: begin
        if (bus.mem_ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign issue = (state == RUN) && !yield_go && found && !full;

  // Round-robin pointer, burst counter and PIO-pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      burst_cnt <= '0;
      pio_pend  <= 1'b0;
    end else begin
      if (issue) ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      // Any idle cycle (including all of YIELD) restarts the burst.
      if (issue) burst_cnt <= (burst_cnt == 8'hFF) ? 8'hFF : burst_cnt + 8'd1;
      else       burst_cnt <= '0;
      // A new PIO read in the same cycle as an ack for the previous one
      // must stay pending.
      if (bus.pio_rd)       pio_pend <= 1'b1;
      else if (bus.mem_ack) pio_pend <= 1'b0;
    end
  end

  // Outstanding-ID FIFO. Issue is blocked when full, so no overflow guard.
  assign full   = (cnt == CW'(OUTST));
  assign empty  = (cnt == '0);
  assign pop    = bus.app_mem_ack && !empty;  // stray acks are dropped
  assign pop_id = id_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (issue) id_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (issue) wr_ptr <= (wr_ptr == PW'(OUTST-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PW'(OUTST-1)) ? '0 : rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Memory-side strobe/address and broadcast response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      rd_q <= issue;
      if (issue) raddr_q <= win_addr;
      if (pop)   rdata_q <= bus.app_mem_rdata;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    pio_mem_rd_arb_lane #(.IDW(IDW), .LANE(i)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue     (issue),
      .win       (win),
      .pop       (pop),
      .pop_id    (pop_id),
      .gnt       (gnt_q[i]),
      .rsp_valid (rsp_q[i])
    );
  end

  assign bus.gnt           = gnt_q;
  assign bus.rsp_valid     = rsp_q;
  assign bus.rsp_data      = rdata_q;
  assign bus.app_mem_rd    = rd_q;
  assign bus.app_mem_raddr = raddr_q;
endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Bench for pio_mem_rd_arb: memory stub with configurable ack latency and
// ack hold-off, PIO read modelling, requester models and a scoreboard of
// expected (requester, data) pairs pushed when each request is presented.
module tb_pio_mem_rd_arb;
  localparam int NREQ = 4, WIDTH = 20, DW = 10, MAX_BURST = 8, OUTST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pio_mem_rd_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DW)) bus ();

  pio_mem_rd_arb #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DW), .MAX_BURST(MAX_BURST), .OUTST(OUTST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory stub ----------------
  logic [WIDTH-1:0] mem [0:(1<<DW)-1];
  typedef struct { logic [DW-1:0] addr; int due; } rd_t;
  rd_t mq[$];
  int  ecnt = 0;
  int  lat  = 3;     // cycles from app_mem_rd to app_mem_ack
  bit  hold = 1'b0;  // withhold app acks
  bit  pio_saved = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        pio_saved = 1'b0;
        bus.app_mem_ack   <= 1'b0;
        bus.app_mem_rdata <= '0;
        bus.mem_ack       <= 1'b0;
      end else begin
        ecnt++;
        if (bus.app_mem_rd) mq.push_back('{bus.app_mem_raddr, ecnt + lat - 1});
        if (!hold && mq.size() > 0 && mq[0].due <= ecnt) begin
          bus.app_mem_ack   <= 1'b1;
          bus.app_mem_rdata <= mem[mq[0].addr];
          void'(mq.pop_front());
        end else begin
          bus.app_mem_ack <= 1'b0;
        end
        // A saved PIO read is served only in a cycle with the app port idle.
        bus.mem_ack <= pio_saved && !bus.app_mem_rd;
        if (pio_saved && !bus.app_mem_rd) pio_saved = 1'b0;
        if (bus.pio_rd) pio_saved = 1'b1;
      end
    end
  end

  // ---------------- requesters + scoreboard ----------------
  typedef struct { int id; logic [WIDTH-1:0] data; } exp_t;
  exp_t sb[$];
  int   rsp_ids[$];
  int   rem [NREQ];
  logic [DW-1:0] ra [NREQ];

  task automatic start(int i, int n, logic [DW-1:0] a);
    rem[i] = n;
    ra[i]  = a;
    bus.raddr[i*DW +: DW] = a;
    bus.req[i] = 1'b1;
    sb.push_back('{i, mem[a]});
  endtask

  task automatic requesters();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.gnt[i]) begin
        if (rem[i] == 0) chk($sformatf("gnt_idle[%0d]", i), 32'(bus.gnt), 0);
        else begin
          rem[i]--;
          if (rem[i] > 0) begin
            ra[i] = ra[i] + 1'b1;
            bus.raddr[i*DW +: DW] = ra[i];
            sb.push_back('{i, mem[ra[i]]});
          end else begin
            bus.req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    int hit;
    if (bus.rsp_valid != '0) begin
      chk("rsp_onehot", 32'($onehot(bus.rsp_valid)), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.rsp_valid[i]) begin
          hit = -1;
          foreach (sb[j]) if (hit < 0 && sb[j].id == i) hit = j;
          rsp_ids.push_back(i);
          if (hit < 0) chk("stray_rsp", 32'(bus.rsp_valid), 0);
          else begin
            chk($sformatf("rsp_data[%0d]", i), 32'(bus.rsp_data), 32'(sb[hit].data));
            sb.delete(hit);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    requesters();
  endtask

  task automatic clear_tb();
    bus.req    = '0;
    bus.raddr  = '0;
    bus.pio_rd = 1'b0;
    sb.delete();
    rsp_ids.delete();
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    hold = 1'b0;
    lat  = 3;
    repeat (2) @(negedge clk);
    chk("rst_gnt",       32'(bus.gnt), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data",  32'(bus.rsp_data), 0);
    chk("rst_app_rd",    32'(bus.app_mem_rd), 0);
    chk("rst_app_raddr", 32'(bus.app_mem_raddr), 0);
    rst_n = 1'b1;
  endtask

  task automatic drain(string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    chk(tag, 32'(sb.size()), 0);
    repeat (6) tick();
  endtask

  initial begin
    int n;
    for (int a = 0; a < (1 << DW); a++) mem[a] = WIDTH'(a * 32'h2F1 + 32'h55);
    mem[10'h05A] = 20'h12345;
    clear_tb();

    // Single read: gnt at T+1, response at T+5.
    do_reset();
    start(1, 1, 10'h05A);
    tick();
    chk("single_gnt",   32'(bus.gnt), 32'h2);
    chk("single_rd",    32'(bus.app_mem_rd), 1);
    chk("single_raddr", 32'(bus.app_mem_raddr), 32'h05A);
    tick();
    chk("single_gnt_off", 32'(bus.gnt), 0);
    tick(); tick();
    chk("single_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("single_rsp_data",  32'(bus.rsp_data), 32'h12345);
    drain("single_drain");

    // Round robin: one read each, grants and responses in order 0..3.
    do_reset();
    for (int i = 0; i < NREQ; i++) start(i, 1, DW'(10'h100 + i));
    for (int k = 0; k < NREQ; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 1 << k);
    end
    drain("rr_drain");
    chk("rr_rsp_cnt", 32'(rsp_ids.size()), 4);
    for (int k = 0; k < rsp_ids.size() && k < 4; k++)
      chk($sformatf("rr_rsp_id%0d", k), 32'(rsp_ids[k]), k);

    // Re-grant guard: a lone requester is granted every other cycle.
    do_reset();
    start(0, 4, 10'h200);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("guard_gnt@%0d", k), 32'(bus.gnt), ((k % 2 == 1) && k <= 7) ? 1 : 0);
    end
    drain("guard_drain");

    // PIO fairness: fast memory so streaming never stalls on the FIFO.
    do_reset();
    lat = 1;
    for (int i = 0; i < NREQ; i++) start(i, 6, DW'(10'h040 * i));
    bus.pio_rd = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) bus.pio_rd = 1'b0;
      chk($sformatf("pio_app_rd@%0d", k), 32'(bus.app_mem_rd), (k <= 8 || k == 12) ? 1 : 0);
      chk($sformatf("pio_gnt@%0d", k), 32'(bus.gnt),
          (k <= 8) ? (1 << ((k - 1) % 4)) : ((k == 12) ? 1 : 0));
      chk($sformatf("pio_mem_ack@%0d", k), 32'(bus.mem_ack), (k == 10) ? 1 : 0);
    end
    drain("pio_drain");

    // Backpressure: acks withheld, issue stops at OUTST outstanding.
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < NREQ; i++) start(i, 2, DW'(10'h300 + 10'h010 * i));
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n += int'(bus.app_mem_rd);
      if (k <= 4) chk($sformatf("bp_gnt@%0d", k), 32'(bus.gnt), 1 << (k - 1));
    end
    chk("bp_issue_cnt", 32'(n), 4);
    chk("bp_rd_stalled", 32'(bus.app_mem_rd), 0);
    hold = 1'b0;
    drain("bp_drain");
    chk("bp_rsp_cnt", 32'(rsp_ids.size()), 8);
    for (int k = 0; k < rsp_ids.size() && k < 8; k++)
      chk($sformatf("bp_rsp_id%0d", k), 32'(rsp_ids[k]), k % 4);

    // Async reset with three reads outstanding.
    do_reset();
    start(0, 1, 10'h0A0);
    start(1, 1, 10'h0B1);
    start(2, 1, 10'h0C2);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",   32'(bus.gnt), 0);
    chk("arst_rsp",   32'(bus.rsp_valid), 0);
    chk("arst_rd",    32'(bus.app_mem_rd), 0);
    chk("arst_raddr", 32'(bus.app_mem_raddr), 0);
    chk("arst_data",  32'(bus.rsp_data), 0);
    clear_tb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.rsp_valid != '0) n++;
    end
    chk("arst_stale_rsp", 32'(n), 0);
    start(3, 1, 10'h3C3);
    tick();
    chk("arst_post_gnt", 32'(bus.gnt), 32'h8);
    tick(); tick(); tick();
    chk("arst_post_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("arst_post_rsp", 32'(bus.rsp_valid), 32'h8);
    drain("arst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
